// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and helpers for the freq_divider switch controller.
package freq_div_ctrl_pkg;

    localparam int FDC_SEL_W = 2;
    localparam int RR_MAX    = 32;
    localparam int RR_IDX_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_GATE,
        S_SWITCH,
        S_SETTLE,
        S_ACK
    } fdc_state_e;

    // Lowest offset from ptr (wrapping at n) with req set; returns ptr if none.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[RR_IDX_W-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/freq_div_ctrl_rr_arbiter.sv
// Round-robin arbiter; the pointer advances past the winner whenever a grant is taken.
module rr_arbiter
    import freq_div_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               pick;

    always_comb begin
        pick    = rr_pick(RR_MAX'(req_i), 32'(ptr_q), NUM_REQ);
        idx_o   = IDX_W'(pick);
        valid_o = |req_i;
        gnt_o   = '0;
        if (valid_o) gnt_o[idx_o] = 1'b1;
        ptr_d = ptr_q;
        if (en_i && valid_o) begin
            ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Glitch-safe divider reprogramming shared between requesters.
// Optional DRAIN timeout with err_o pulse: define FREQ_DIV_CTRL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | arbitrate requests; equal selector goes straight to ACK
// DRAIN  | wait for a falling edge of the synchronised divided clock
// GATE   | clk_en_o low, one cycle
// SWITCH | new selector driven, div_rst_o pulsed
// SETTLE | hold gated for SETTLE_CYC cycles
// ACK    | clk_en_o back high, ack_o pulse to the granted requester
module freq_div_ctrl
    import freq_div_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int SEL_W       = FDC_SEL_W,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*SEL_W-1:0] sel_i,
    input  logic                     div_clk_i,
    output logic [SEL_W-1:0]         selector_o,
    output logic                     div_rst_o,
    output logic                     clk_en_o,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     busy_o
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
    ,output logic                    err_o
`endif
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    fdc_state_e         state_q;
    logic [SEL_W-1:0]   sel_q, selector_q, req_sel;
    logic [NUM_REQ-1:0] gnt_q, ack_q, gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               div_rst_q, clk_en_q, fall;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         sync_q;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
    logic               err_q;
    assign err_o = err_q;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .en_i    (state_q == S_IDLE),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_comb begin
        req_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) req_sel = sel_i[k*SEL_W +: SEL_W];
        end
    end

    // sync_q[1] is the synchronised sample, sync_q[2] the previous one
    assign fall = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            selector_q <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            div_rst_q  <= 1'b0;
            clk_en_q   <= 1'b1;
            cnt_q      <= '0;
            sync_q     <= '0;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[1:0], div_clk_i};
            ack_q     <= '0;
            div_rst_q <= 1'b0;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        gnt_q <= gnt;
                        sel_q <= req_sel;
                        if (req_sel == selector_q) begin
                            state_q <= S_ACK;
                            ack_q   <= gnt;
                        end else begin
                            state_q <= S_DRAIN;
                            cnt_q   <= CNT_W'(TIMEOUT_CYC - 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (fall) begin
                        state_q  <= S_GATE;
                        clk_en_q <= 1'b0;
                    end
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        state_q  <= S_GATE;
                        clk_en_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
                S_GATE: begin
                    state_q    <= S_SWITCH;
                    selector_q <= sel_q;
                    div_rst_q  <= 1'b1;
                end
                S_SWITCH: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_ACK;
                        clk_en_q <= 1'b1;
                        ack_q    <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_ACK:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign selector_o = selector_q;
    assign div_rst_o  = div_rst_q;
    assign clk_en_o   = clk_en_q;
    assign ack_o      = ack_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: stimulus queues expected acks, a monitor checks them.
module tb_freq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] req;
    logic [3:0] sel;
    logic       div_clk;
    logic [1:0] selector;
    logic       div_rst, clk_en, busy;
    logic [1:0] ack;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    freq_div_ctrl #(.NUM_REQ(2), .SEL_W(2), .SETTLE_CYC(4), .TIMEOUT_CYC(64)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req),
        .sel_i      (sel),
        .div_clk_i  (div_clk),
        .selector_o (selector),
        .div_rst_o  (div_rst),
        .clk_en_o   (clk_en),
        .ack_o      (ack),
        .busy_o     (busy)
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
        ,.err_o     (err)
`endif
    );

    typedef struct {
        logic [1:0] ack;
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   div_run  = 1'b0;
    bit   div_hold = 1'b0;
    logic m1, m2, m3;
    logic fall_m;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the 2-flop synchroniser plus edge register
    always @(posedge clk) begin
        if (!rst_i) begin
            m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0;
        end else begin
            m1 <= div_clk; m2 <= m1; m3 <= m2;
        end
    end
    assign fall_m = m3 & ~m2;

    initial begin
        div_clk = 1'b1;
        forever begin
            @(negedge clk);
            if (div_hold) div_clk = 1'b1;
            else if (div_run && (cyc % 8 == 0)) div_clk = ~div_clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic find_fall(output int d);
        d = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (fall_m === 1'b1) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fall_wait: no divided-clock fall within 60 cycles (cycle %0d)", cyc);
            d = cyc;
        end
    endtask

    task automatic push_exp(input logic [1:0] a, input logic [1:0] s, input int t);
        exp_t e;
        e.ack = a; e.sel = s; e.cyc = t;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset(input int n);
        rst_i = 1'b0;
        req   = '0;
        repeat (n) @(negedge clk);
        rst_i = 1'b1;
    endtask

    // Monitor: every ack pulse must match the head of the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", ack, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_value", ack, e.ack);
                    check("ack_selector", selector, e.sel);
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_clk_en", clk_en, 1'b1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, d2;
        rst_i = 1'b0;
        req   = '0;
        sel   = '0;
        repeat (2) @(negedge clk);
        check("rst_selector", selector, 2'd0);
        check("rst_clk_en", clk_en, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", ack, 2'b00);
        check("rst_div_rst", div_rst, 1'b0);
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
        check("rst_err", err, 1'b0);
`endif
        rst_i   = 1'b1;
        div_run = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Single change: req0 -> selector 2
        sel[1:0] = 2'd2;
        req[0]   = 1'b1;
        find_fall(d);
        push_exp(2'b01, 2'd2, d + 7);
        check("chg_clk_en_at_fall", clk_en, 1'b1);
        wait_cyc(d + 1);
        check("chg_gate_clk_en", clk_en, 1'b0);
        check("chg_gate_div_rst", div_rst, 1'b0);
        check("chg_gate_selector", selector, 2'd0);
        wait_cyc(d + 2);
        check("chg_switch_selector", selector, 2'd2);
        check("chg_switch_div_rst", div_rst, 1'b1);
        wait_cyc(d + 3);
        check("chg_settle_div_rst", div_rst, 1'b0);
        check("chg_settle_clk_en", clk_en, 1'b0);
        wait_cyc(d + 6);
        check("chg_last_settle_clk_en", clk_en, 1'b0);
        wait_cyc(d + 7);
        req[0] = 1'b0;
        wait_cyc(d + 8);
        check("chg_busy_after_ack", busy, 1'b0);

        // Fast path: req1 asks for the current selector
        sel[3:2] = 2'd2;
        req[1]   = 1'b1;
        c = cyc;
        push_exp(2'b10, 2'd2, c + 1);
        check("fast_busy_grant", busy, 1'b0);
        wait_cyc(c + 1);
        check("fast_div_rst", div_rst, 1'b0);
        check("fast_clk_en", clk_en, 1'b1);
        req[1] = 1'b0;
        wait_cyc(c + 2);
        check("fast_busy_after", busy, 1'b0);
        check("fast_selector", selector, 2'd2);

        // Contention after reset (pointer 0): req0 sel=1 first, then req1 sel=3
        apply_reset(2);
        check("rst2_selector", selector, 2'd0);
        sel = {2'd3, 2'd1};
        req = 2'b11;
        find_fall(d);
        push_exp(2'b01, 2'd1, d + 7);
        wait_cyc(d + 2);
        check("cont_first_selector", selector, 2'd1);
        wait_cyc(d + 7);
        req[0] = 1'b0;
        wait_cyc(d + 8);
        check("cont_idle_between", busy, 1'b0);
        find_fall(d2);
        push_exp(2'b10, 2'd3, d2 + 7);
        wait_cyc(d2 + 2);
        check("cont_second_selector", selector, 2'd3);
        wait_cyc(d2 + 7);
        req[1] = 1'b0;
        wait_cyc(d2 + 9);
        check("cont_final_selector", selector, 2'd3);
        check("cont_final_busy", busy, 1'b0);

        // Reset in the middle of SETTLE: no ack, selector back to 0
        sel[1:0] = 2'd2;
        req[0]   = 1'b1;
        find_fall(d);
        wait_cyc(d + 4);
        check("mid_settle_clk_en", clk_en, 1'b0);
        check("mid_settle_selector", selector, 2'd2);
        rst_i = 1'b0;
        req   = '0;
        wait_cyc(d + 5);
        check("mid_rst_selector", selector, 2'd0);
        check("mid_rst_clk_en", clk_en, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", ack, 2'b00);
        rst_i = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_still_idle", busy, 1'b0);

        // DRAIN with the divided clock stuck high
        div_hold = 1'b1;
        repeat (6) @(negedge clk);
        sel[1:0] = 2'd3;
        req[0]   = 1'b1;
        c = cyc;
`ifdef FREQ_DIV_CTRL_TIMEOUT_EN
        push_exp(2'b01, 2'd3, c + 71);
        wait_cyc(c + 64);
        check("to_before_err", err, 1'b0);
        check("to_drain_clk_en", clk_en, 1'b1);
        wait_cyc(c + 65);
        check("to_err_pulse", err, 1'b1);
        check("to_gate_clk_en", clk_en, 1'b0);
        wait_cyc(c + 66);
        check("to_err_single", err, 1'b0);
        check("to_switch_div_rst", div_rst, 1'b1);
        wait_cyc(c + 71);
        req[0] = 1'b0;
        wait_cyc(c + 72);
        check("to_busy_after", busy, 1'b0);
`else
        wait_cyc(c + 100);
        check("stuck_busy", busy, 1'b1);
        check("stuck_clk_en", clk_en, 1'b1);
        check("stuck_selector", selector, 2'd0);
        apply_reset(2);
        check("stuck_rst_busy", busy, 1'b0);
`endif
        div_hold = 1'b0;

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
